// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: ALU op encodings, default datapath width and the
// response-slot states used by the ALU arbiter.
package riscv_pkg;

  localparam int DEFAULT_XLEN = 32;

  localparam logic [3:0] ALU_ADD   = 4'h0;
  localparam logic [3:0] ALU_SUB   = 4'h1;
  localparam logic [3:0] ALU_SLL   = 4'h2;
  localparam logic [3:0] ALU_SLT   = 4'h3;
  localparam logic [3:0] ALU_SLTU  = 4'h4;
  localparam logic [3:0] ALU_XOR   = 4'h5;
  localparam logic [3:0] ALU_SRL   = 4'h6;
  localparam logic [3:0] ALU_SRA   = 4'h7;
  localparam logic [3:0] ALU_OR    = 4'h8;
  localparam logic [3:0] ALU_AND   = 4'h9;
  localparam logic [3:0] ALU_LUI   = 4'hA;  // passes operand_b (pre-shifted immediate)
  localparam logic [3:0] ALU_AUIPC = 4'hB;  // operand_a is the pc
  localparam logic [3:0] ALU_OP_MAX = ALU_AUIPC;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rsp_state_e;

endpackage

// File: rtl/alu.sv
// Combinational RV32I integer ALU; illegal encodings yield 0 (and so zero=1).
// Zero latency, no flow control.
module alu
  import riscv_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [3:0]      alu_op,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  logic [4:0] shamt;
  assign shamt = operand_b[4:0];

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD:   result = operand_a + operand_b;
      ALU_SUB:   result = operand_a - operand_b;
      ALU_SLL:   result = operand_a << shamt;
      ALU_SLT:   result = XLEN'($signed(operand_a) < $signed(operand_b));
      ALU_SLTU:  result = XLEN'(operand_a < operand_b);
      ALU_XOR:   result = operand_a ^ operand_b;
      ALU_SRL:   result = operand_a >> shamt;
      ALU_SRA:   result = $unsigned($signed(operand_a) >>> shamt);
      ALU_OR:    result = operand_a | operand_b;
      ALU_AND:   result = operand_a & operand_b;
      ALU_LUI:   result = operand_b;
      ALU_AUIPC: result = operand_a + operand_b;
      default:   result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU among NUM_REQ valid/ready requesters.
// One-cycle registered response; req_ready drops while the response stalls.
module alu_arbiter
  import riscv_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = DEFAULT_XLEN,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*XLEN-1:0] req_a,
  input  logic [NUM_REQ*XLEN-1:0] req_b,
  input  logic [NUM_REQ*4-1:0]    req_op,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [XLEN-1:0]         rsp_result,
  output logic                    rsp_zero,
  output logic                    rsp_err
);

  // {found, index}: first valid requester at or after ptr, wrapping.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [ID_W-1:0]    ptr);
    logic [ID_W:0] pick;
    int            idx;
    pick = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (valid[idx]) pick = {1'b1, ID_W'(idx)};
    end
    return pick;
  endfunction

  rsp_state_e       state_q, state_d;
  logic [ID_W-1:0]  rr_ptr, ptr_nxt, gnt_idx;
  logic             gnt_vld, can_accept, accept, op_err, alu_zero;
  logic [XLEN-1:0]  sel_a, sel_b, alu_res;
  logic [3:0]       sel_op;

  assign {gnt_vld, gnt_idx} = rr_pick(req_valid, rr_ptr);
  assign rsp_valid  = (state_q == FULL);
  assign can_accept = !rsp_valid || rsp_ready;
  assign accept     = rst_n && gnt_vld && can_accept;
  assign ptr_nxt    = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
  assign op_err     = (sel_op > ALU_OP_MAX);

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        sel_a  = req_a[i*XLEN +: XLEN];
        sel_b  = req_b[i*XLEN +: XLEN];
        sel_op = req_op[i*4 +: 4];
      end
    end
  end

  alu #(.XLEN(XLEN)) u_alu (
    .operand_a (sel_a),
    .operand_b (sel_b),
    .alu_op    (sel_op),
    .result    (alu_res),
    .zero      (alu_zero)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (rsp_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      rr_ptr     <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rsp_id     <= gnt_idx;
        rsp_result <= alu_res;
        rsp_zero   <= alu_zero;
        rsp_err    <= op_err;
        rr_ptr     <= ptr_nxt;
      end
    end
  end

endmodule
